sprite_pixel_unit: RTL and testbench

Per-scanline sprite output stage of the PPU: holds the eight sprite slots (attribute, X counter, pattern low/high) produced by the sprite fetch phase and shifts them out pixel by pixel during the visible line. Each dot, it resolves slot priority and drives the winning sprite's 4-bit palette index and its priority bit to the pixel mux. It also produces the sticky sprite-0 hit flag.

---
 rtl/sprite_pixel_unit_if.sv | 41 ++++
 rtl/sprite_pixel_unit.sv | 138 +++++++++++++
 tb/tb_sprite_pixel_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pixel_unit_if.sv
// Sprite pixel unit bus: slot loads, dot control, mask bits and pixel results.
// The PPU sequencer drives as master; sprite_pixel_unit consumes as slave.
interface sprite_pixel_unit_if;
    logic       clock_EN;
    logic       load_EN;
    logic [2:0] load_slot;
    logic [7:0] load_attr;
    logic [7:0] load_x;
    logic [7:0] load_patLo;
    logic [7:0] load_patHi;
    logic       pixelShifty_EN;
    logic [7:0] pixelX;
    logic       showSprites;
    logic       showLeftSprites;
    logic       showBackground;
    logic       showLeftBackground;
    logic       sprite0InLine;
    logic       bgOpaque;
    logic       resetFlags;
    logic [3:0] spritePixel_OUT;
    logic       spritePriority_OUT;
    logic       spriteCollision;

    modport master (
        output clock_EN, load_EN, load_slot, load_attr, load_x,
        output load_patLo, load_patHi, pixelShifty_EN, pixelX,
        output showSprites, showLeftSprites,
        output showBackground, showLeftBackground,
        output sprite0InLine, bgOpaque, resetFlags,
        input  spritePixel_OUT, spritePriority_OUT, spriteCollision
    );

    modport slave (
        input  clock_EN, load_EN, load_slot, load_attr, load_x,
        input  load_patLo, load_patHi, pixelShifty_EN, pixelX,
        input  showSprites, showLeftSprites,
        input  showBackground, showLeftBackground,
        input  sprite0InLine, bgOpaque, resetFlags,
        output spritePixel_OUT, spritePriority_OUT, spriteCollision
    );
endinterface

// File: rtl/sprite_pixel_unit.sv
// Per-scanline sprite output stage: eight slots, priority resolve, sprite-0 hit.
// Optional feature macro: SPRITE_ZERO_HIT_EN (sticky sprite-0 hit logic).
module sprite_pixel_unit (
    input logic clock,
    input logic reset,
    sprite_pixel_unit_if.slave bus
);

    logic [7:0] x_count [8];
    logic [1:0] pal     [8];
    logic       pri     [8];
    logic [7:0] pat_lo  [8];
    logic [7:0] pat_hi  [8];

    logic [1:0] color [8];
    logic [3:0] win_pix;
    logic       win_pri;
    logic       found;
    logic       clip;
    logic       advance;

    assign advance = bus.clock_EN && bus.pixelShifty_EN;

    assign clip = !bus.showSprites ||
                  ((bus.pixelX < 8'd8) && !bus.showLeftSprites);

    // Slot color: only a slot whose X counter has expired shows its MSBs.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            color[i] = 2'b00;
            if (x_count[i] == 8'd0) begin
                color[i] = {pat_hi[i][7], pat_lo[i][7]};
            end
        end
    end

    // Priority resolve: lowest-index opaque slot wins, clipping forces zero.
    always_comb begin
        win_pix = 4'h0;
        win_pri = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && (color[i] != 2'b00)) begin
                found   = 1'b1;
                win_pix = {pal[i], color[i]};
                win_pri = pri[i];
            end
        end
        if (clip) begin
            win_pix = 4'h0;
            win_pri = 1'b0;
        end
    end

    // Slot state: a load overrides the advance for its own slot only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                x_count[i] <= 8'd0;
                pal[i]     <= 2'b00;
                pri[i]     <= 1'b0;
                pat_lo[i]  <= 8'd0;
                pat_hi[i]  <= 8'd0;
            end
        end else if (bus.clock_EN) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.load_EN && (bus.load_slot == 3'(i))) begin
                    x_count[i] <= bus.load_x;
                    pal[i]     <= bus.load_attr[1:0];
                    pri[i]     <= bus.load_attr[5];
                    pat_lo[i]  <= bus.load_patLo;
                    pat_hi[i]  <= bus.load_patHi;
                end else if (bus.pixelShifty_EN) begin
                    if (x_count[i] != 8'd0) begin
                        x_count[i] <= x_count[i] - 8'd1;
                    end else begin
                        pat_lo[i] <= {pat_lo[i][6:0], 1'b0};
                        pat_hi[i] <= {pat_hi[i][6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Registered pixel result; holds on dots that do not advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.spritePixel_OUT    <= 4'h0;
            bus.spritePriority_OUT <= 1'b0;
        end else if (advance) begin
            bus.spritePixel_OUT    <= win_pix;
            bus.spritePriority_OUT <= win_pri;
        end
    end

`ifdef SPRITE_ZERO_HIT_EN
    logic hit;
    logic left_clip;
    logic unused_bits;

    assign unused_bits = ^{bus.load_attr[7:6], bus.load_attr[4:2]};

    assign left_clip = (bus.pixelX < 8'd8) &&
                       (!bus.showLeftSprites || !bus.showLeftBackground);

    // Slot 0 is tested on its own color, independent of who wins the dot.
    assign hit = bus.sprite0InLine &&
                 (color[0] != 2'b00) &&
                 bus.bgOpaque &&
                 bus.showSprites &&
                 bus.showBackground &&
                 (bus.pixelX != 8'd255) &&
                 !left_clip;

    // Sticky hit flag; a flag clear beats a simultaneous hit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.spriteCollision <= 1'b0;
        end else if (bus.clock_EN) begin
            if (bus.resetFlags) begin
                bus.spriteCollision <= 1'b0;
            end else if (bus.pixelShifty_EN && hit) begin
                bus.spriteCollision <= 1'b1;
            end
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{bus.load_attr[7:6], bus.load_attr[4:2],
                           bus.sprite0InLine, bus.bgOpaque,
                           bus.showBackground, bus.showLeftBackground,
                           bus.resetFlags};

    assign bus.spriteCollision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_pixel_unit.sv
// Directed bench for sprite_pixel_unit with a queue scoreboard.
// Expected pixel/priority/collision are pushed per step and popped after the edge.
module tb_sprite_pixel_unit;

`ifdef SPRITE_ZERO_HIT_EN
    localparam logic HIT_EN = 1'b1;
`else
    localparam logic HIT_EN = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [3:0] pix;
        logic       pri;
        logic       col;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    sprite_pixel_unit_if bus ();

    sprite_pixel_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_front();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty got 0 entries exp 1");
        end else begin
            e = sb.pop_front();
            assert (bus.spritePixel_OUT === e.pix) else begin
                errors++;
                $error("FAIL %s pix got %h exp %h",
                       e.tag, bus.spritePixel_OUT, e.pix);
            end
            checks++;
            assert (bus.spritePriority_OUT === e.pri) else begin
                errors++;
                $error("FAIL %s pri got %b exp %b",
                       e.tag, bus.spritePriority_OUT, e.pri);
            end
            checks++;
            assert (bus.spriteCollision === e.col) else begin
                errors++;
                $error("FAIL %s col got %b exp %b",
                       e.tag, bus.spriteCollision, e.col);
            end
        end
    endtask

    task automatic dot(input string tag, input logic [7:0] px,
                       input logic ce, input logic sh,
                       input logic [3:0] ep, input logic epr,
                       input logic ec);
        bus.clock_EN       = ce;
        bus.pixelShifty_EN = sh;
        bus.pixelX         = px;
        sb.push_back('{tag, ep, epr, ec});
        @(posedge clock);
        #1;
        check_front();
        bus.clock_EN       = 1'b0;
        bus.pixelShifty_EN = 1'b0;
    endtask

    task automatic load(input logic [2:0] s, input logic [7:0] a,
                        input logic [7:0] x, input logic [7:0] lo,
                        input logic [7:0] hi);
        bus.clock_EN       = 1'b1;
        bus.pixelShifty_EN = 1'b0;
        bus.load_EN        = 1'b1;
        bus.load_slot      = s;
        bus.load_attr      = a;
        bus.load_x         = x;
        bus.load_patLo     = lo;
        bus.load_patHi     = hi;
        @(posedge clock);
        #1;
        bus.load_EN  = 1'b0;
        bus.clock_EN = 1'b0;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 8; i++) begin
            load(3'(i), 8'h00, 8'h00, 8'h00, 8'h00);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.clock_EN = 0; bus.load_EN = 0; bus.load_slot = 0;
        bus.load_attr = 0; bus.load_x = 0;
        bus.load_patLo = 0; bus.load_patHi = 0;
        bus.pixelShifty_EN = 0; bus.pixelX = 0;
        bus.showSprites = 1; bus.showLeftSprites = 1;
        bus.showBackground = 1; bus.showLeftBackground = 1;
        bus.sprite0InLine = 0; bus.bgOpaque = 0; bus.resetFlags = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        sb.push_back('{"reset_state", 4'h0, 1'b0, 1'b0});
        check_front();

        // 1: single sprite at X=10
        load(3'd3, 8'h02, 8'd10, 8'h80, 8'h80);
        for (int d = 0; d <= 20; d++) begin
            dot("t1_dot", 8'(d), 1'b1, 1'b1,
                (d == 10) ? 4'hB : 4'h0, 1'b0, 1'b0);
        end

        // 2: two overlapping sprites, slot 1 wins; hold checks mid-run
        clear_slots();
        load(3'd1, 8'h01, 8'd5, 8'hFF, 8'h00);
        load(3'd4, 8'h23, 8'd5, 8'h00, 8'hFF);
        for (int d = 0; d <= 7; d++) begin
            dot("t2_dot", 8'(d), 1'b1, 1'b1,
                (d >= 5) ? 4'h5 : 4'h0, 1'b0, 1'b0);
        end
        dot("t2_hold_noshift", 8'd8, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
        dot("t2_hold_noce", 8'd8, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
        for (int d = 8; d <= 15; d++) begin
            dot("t2_dot", 8'(d), 1'b1, 1'b1,
                (d <= 12) ? 4'h5 : 4'h0, 1'b0, 1'b0);
        end

        // 2b: priority bit, X=0 active at once, load during shift, clip
        clear_slots();
        load(3'd4, 8'h23, 8'd0, 8'h00, 8'hFF);
        dot("t2b_x0", 8'd20, 1'b1, 1'b1, 4'hE, 1'b1, 1'b0);
        bus.load_EN = 1'b1; bus.load_slot = 3'd2; bus.load_attr = 8'h00;
        bus.load_x = 8'd0; bus.load_patLo = 8'h80; bus.load_patHi = 8'h00;
        dot("t2b_load_shift", 8'd21, 1'b1, 1'b1, 4'hE, 1'b1, 1'b0);
        bus.load_EN = 1'b0;
        dot("t2b_loaded_wins", 8'd22, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
        dot("t2b_after", 8'd23, 1'b1, 1'b1, 4'hE, 1'b1, 1'b0);
        bus.showSprites = 1'b0;
        dot("t2b_hidden", 8'd24, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
        bus.showSprites = 1'b1;
        dot("t2b_shown", 8'd25, 1'b1, 1'b1, 4'hE, 1'b1, 1'b0);

        // 3: sprite-0 hit suppressed by left clip, then set at dot 8
        clear_slots();
        bus.sprite0InLine = 1'b1; bus.bgOpaque = 1'b1;
        bus.showLeftSprites = 1'b0;
        load(3'd0, 8'h00, 8'd2, 8'hFF, 8'h00);
        for (int d = 0; d <= 12; d++) begin
            dot("t3_dot", 8'(d), 1'b1, 1'b1,
                (d == 8 || d == 9) ? 4'h1 : 4'h0, 1'b0,
                HIT_EN && (d >= 8));
        end
        bus.resetFlags = 1'b1;
        dot("t3_clear", 8'd13, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        bus.resetFlags = 1'b0;
        bus.showLeftSprites = 1'b1;

        // 4: no hit at pixelX 255
        clear_slots();
        load(3'd0, 8'h00, 8'd250, 8'hFF, 8'h00);
        for (int d = 0; d <= 255; d++) begin
            bus.bgOpaque = (d == 255);
            dot("t4_dot", 8'(d), 1'b1, 1'b1,
                (d >= 250) ? 4'h1 : 4'h0, 1'b0, 1'b0);
        end

        // 5: clear beats hit, then async reset mid-sprite
        clear_slots();
        bus.bgOpaque = 1'b1;
        load(3'd0, 8'h00, 8'd0, 8'hFF, 8'h00);
        bus.resetFlags = 1'b1;
        dot("t5_clear_wins", 8'd20, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
        bus.resetFlags = 1'b0;
        dot("t5_hit", 8'd21, 1'b1, 1'b1, 4'h1, 1'b0, HIT_EN);
        sb.push_back('{"t5_async_reset", 4'h0, 1'b0, 1'b0});
        reset = 1'b1;
        #2;
        check_front();
        reset = 1'b0;
        dot("t5_after_reset", 8'd23, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_left got %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
